// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared pipeline types for the sequential divider
package seq_divider_pkg;

    typedef logic [31:0] i32;
    typedef logic [63:0] i64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    localparam int DIV_ITER = 32;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration on the {remainder, quotient} register
module div_step
    import seq_divider_pkg::*;
(
    input  i64 w,
    input  i32 bq,
    output i64 w_next
);

    i64          w_shift;
    logic [32:0] rem_wide;
    logic [32:0] rem_sub;

    always_comb begin
        w_shift  = {w[62:0], 1'b0};
        // The bit shifted out of w[63] is the 33rd bit of the partial remainder.
        rem_wide = {w[63], w_shift[63:32]};
        rem_sub  = rem_wide - {1'b0, bq};
        w_next   = w_shift;
        if (rem_wide >= {1'b0, bq}) begin
            w_next = {rem_sub[31:0], w_shift[31:1], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned 32/32 restoring divider, one quotient bit per cycle
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int ITER = DIV_ITER
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  i32   a,
    input  i32   b,
    output logic done,
    output i64   c
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    div_state_t       state_q, state_d;
    i64               w_q, w_d;
    i32               bq_q, bq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    i64               c_q, c_d;
    i64               w_step;

    div_step u_div_step (
        .w      (w_q),
        .bq     (bq_q),
        .w_next (w_step)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        bq_d    = bq_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid) begin
                    if (a < b) begin
                        // Quotient is zero and the dividend is the remainder.
                        c_d     = {a, 32'h0};
                        state_d = S_DONE;
                    end else begin
                        w_d     = {32'h0, a};
                        bq_d    = b;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!valid) begin
                    state_d = S_IDLE;
                end else begin
                    w_d   = w_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        c_d     = w_step;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            bq_q    <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            bq_q    <= bq_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign done = (state_q == S_DONE);
    assign c    = c_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        done;
    logic [63:0] c;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_c;

    seq_divider #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .a     (a),
        .b     (b),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
    endfunction

    function automatic int ref_latency(input logic [31:0] x, input logic [31:0] y);
        return (x < y) ? 1 : 33;
    endfunction

    // Called in an IDLE cycle (cycle 0); returns in the cycle after done.
    task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] exp_c;
        int lat;
        exp_c = ref_result(x, y);
        lat   = ref_latency(x, y);
        a = x;
        b = y;
        valid = 1'b1;
        chk1({tag, "_done_c0"}, done, 1'b0);
        for (int n = 1; n <= lat + 1; n++) begin
            tick();
            if (n == lat) begin
                chk1({tag, "_done"}, done, 1'b1);
                chk64({tag, "_c"}, c, exp_c);
                valid = 1'b0;
            end else if (n == lat + 1) begin
                chk1({tag, "_done_after"}, done, 1'b0);
                chk64({tag, "_c_hold"}, c, exp_c);
            end else if (done !== 1'b0) begin
                chk1($sformatf("%s_early_done_c%0d", tag, n), done, 1'b0);
            end
        end
        last_c = exp_c;
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1;
        valid = 1'b0;
        a = '0;
        b = '0;
        #1;
        chk1("reset_done", done, 1'b0);
        chk64("reset_c", c, 64'h0);
        tick();
        reset = 1'b0;
        tick();

        run_div("d100_7", 32'd100, 32'd7);
        chk64("d100_7_model", last_c, {32'd2, 32'd14});
        run_div("fast5_9", 32'd5, 32'd9);
        run_div("divzero", 32'h1234, 32'h0);
        run_div("max_by1", 32'hFFFF_FFFF, 32'd1);
        run_div("big_div", 32'hFFFF_FFFF, 32'h8000_0001);
        run_div("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Abort: drop valid in cycle 10; no done, c keeps the previous result.
        a = 32'd100;
        b = 32'd7;
        valid = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (done !== 1'b0) chk1($sformatf("abort_early_done_c%0d", n), done, 1'b0);
        end
        valid = 1'b0;
        tick();
        chk1("abort_no_done", done, 1'b0);
        chk64("abort_c_hold", c, last_c);
        run_div("restart20_3", 32'd20, 32'd3);

        // Reset in cycle 15 of a divide clears outputs immediately.
        a = 32'd100;
        b = 32'd7;
        valid = 1'b1;
        for (int n = 1; n <= 15; n++) tick();
        reset = 1'b1;
        valid = 1'b0;
        #1;
        chk1("midreset_done", done, 1'b0);
        chk64("midreset_c", c, 64'h0);
        tick();
        reset = 1'b0;
        tick();
        chk1("postreset_done", done, 1'b0);

        // Back-to-back with valid held: second request starts in the IDLE cycle 34.
        a = 32'd100;
        b = 32'd7;
        valid = 1'b1;
        for (int n = 1; n <= 68; n++) begin
            tick();
            if (n == 33) begin
                chk1("b2b_done1", done, 1'b1);
                chk64("b2b_c1", c, ref_result(32'd100, 32'd7));
                a = 32'd9;
                b = 32'd4;
            end else if (n == 67) begin
                chk1("b2b_done2", done, 1'b1);
                chk64("b2b_c2", c, {32'd1, 32'd2});
                valid = 1'b0;
            end else if (n == 68) begin
                chk1("b2b_done_after", done, 1'b0);
            end else if (done !== 1'b0) begin
                chk1($sformatf("b2b_stray_done_c%0d", n), done, 1'b0);
            end
        end
        last_c = {32'd1, 32'd2};

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 255);
                2: rb = (i % 8 == 2) ? 32'h0 : ($urandom | 32'h8000_0000);
                default: rb = ra >> $urandom_range(0, 31);
            endcase
            run_div($sformatf("rand%0d", i), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
